// File: rtl/player_input_hub.sv
// player_input_hub: per-player button conditioning and frame-synchronous command snapshots.
//
// Each raw button bit passes through a 2-flop synchronizer and a debounce counter before it is
// used. Direction is derived from the debounced levels with fixed priority
// up > down > left > right. Fire events come from debounced rising edges and, optionally,
// periodic auto-repeat. Each i_frame_tick captures a snapshot of direction and pending fire.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_btn        raw buttons, player p bits [5p+4:5p] = {fire,right,left,down,up}
//   i_frame_tick one-cycle snapshot request
//   o_held       debounced button levels, same layout as i_btn
//   o_dir        latched direction per player (0 up, 1 down, 2 left, 3 right, 4 idle)
//   o_cmd_valid  per-player pulse marking a new snapshot
//   o_fire       per-player fire command pulse, coincident with o_cmd_valid
//   o_led        LED drive, mirrors o_held
module player_input_hub #(
  parameter int unsigned N_PLAYERS       = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned AUTO_REPEAT     = 1,
  parameter int unsigned REPEAT_CYCLES   = 6250000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5*N_PLAYERS-1:0] i_btn,
  input  logic                   i_frame_tick,
  output logic [5*N_PLAYERS-1:0] o_held,
  output logic [3*N_PLAYERS-1:0] o_dir,
  output logic [N_PLAYERS-1:0]   o_cmd_valid,
  output logic [N_PLAYERS-1:0]   o_fire,
  output logic [5*N_PLAYERS-1:0] o_led
);

  localparam int unsigned NB = 5 * N_PLAYERS;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RW = $clog2(REPEAT_CYCLES);
  localparam logic [DW-1:0] DbLast  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RptLast = RW'(REPEAT_CYCLES - 1);
  localparam logic [3*N_PLAYERS-1:0] DirIdle = {N_PLAYERS{3'd4}};

  logic [NB-1:0]                 sync1_q, sync2_q;
  logic [NB-1:0]                 held_q, held_d;
  logic [NB-1:0][DW-1:0]         db_cnt_q, db_cnt_d;
  logic [N_PLAYERS-1:0]          fire_prev_q;
  logic [N_PLAYERS-1:0][RW-1:0]  rpt_q, rpt_d;
  logic [N_PLAYERS-1:0]          pend_q, pend_d;
  logic [3*N_PLAYERS-1:0]        dir_q, dir_d;
  logic [N_PLAYERS-1:0]          valid_q, valid_d;
  logic [N_PLAYERS-1:0]          fire_q, fire_d;

  // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = '0;
    for (int b = 0; b < NB; b++) begin
      if (sync2_q[b] != held_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          held_d[b] = ~held_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  // Fire events, pending flags and frame snapshots.
  always_comb begin
    logic       fire_lvl;
    logic       rise;
    logic       rpt_evt;
    logic       evt;
    logic [4:0] h;
    logic [2:0] dir_c;
    rpt_d   = rpt_q;
    pend_d  = pend_q;
    dir_d   = dir_q;
    valid_d = i_frame_tick ? '1 : '0;
    fire_d  = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      h        = held_q[5*p +: 5];
      fire_lvl = h[4];
      rise     = fire_lvl & ~fire_prev_q[p];
      rpt_evt  = 1'b0;
      if (!fire_lvl || rise) begin
        rpt_d[p] = '0;
      end else if (rpt_q[p] == RptLast) begin
        rpt_d[p] = '0;
        rpt_evt  = 1'b1;
      end else begin
        rpt_d[p] = rpt_q[p] + 1'b1;
      end
      evt = rise | ((AUTO_REPEAT != 0) & rpt_evt);

      if (h[0])      dir_c = 3'd0;
      else if (h[1]) dir_c = 3'd1;
      else if (h[2]) dir_c = 3'd2;
      else if (h[3]) dir_c = 3'd3;
      else           dir_c = 3'd4;

      // An event in the tick cycle is held back for the following snapshot.
      if (i_frame_tick) begin
        dir_d[3*p +: 3] = dir_c;
        fire_d[p]       = pend_q[p];
        pend_d[p]       = evt;
      end else begin
        pend_d[p] = pend_q[p] | evt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      held_q      <= '0;
      db_cnt_q    <= '0;
      fire_prev_q <= '0;
      rpt_q       <= '0;
      pend_q      <= '0;
      dir_q       <= DirIdle;
      valid_q     <= '0;
      fire_q      <= '0;
    end else begin
      sync1_q  <= i_btn;
      sync2_q  <= sync1_q;
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
      for (int p = 0; p < N_PLAYERS; p++) begin
        fire_prev_q[p] <= held_q[5*p+4];
      end
      rpt_q   <= rpt_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      fire_q  <= fire_d;
    end
  end

  assign o_held      = held_q;
  assign o_led       = held_q;
  assign o_dir       = dir_q;
  assign o_cmd_valid = valid_q;
  assign o_fire      = fire_q;

endmodule

// File: tb/tb_player_input_hub.sv
// Testbench for player_input_hub: directed stimulus, a history-based behavioural model checked
// every cycle, and literal expectations for key scenarios.
module tb_player_input_hub;

  localparam int NP = 2;
  localparam int NB = 10;
  localparam int DB = 4;
  localparam int RP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] i_btn = '0;
  logic          i_frame_tick = 1'b0;

  logic [NB-1:0]   a_held, a_led, b_held, b_led;
  logic [3*NP-1:0] a_dir, b_dir;
  logic [NP-1:0]   a_valid, a_fire, b_valid, b_fire;

  player_input_hub #(
    .N_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .AUTO_REPEAT(1), .REPEAT_CYCLES(RP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_frame_tick(i_frame_tick),
    .o_held(a_held), .o_dir(a_dir), .o_cmd_valid(a_valid), .o_fire(a_fire), .o_led(a_led)
  );

  player_input_hub #(
    .N_PLAYERS(NP), .DEBOUNCE_CYCLES(DB), .AUTO_REPEAT(0), .REPEAT_CYCLES(RP)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .i_btn(i_btn), .i_frame_tick(i_frame_tick),
    .o_held(b_held), .o_dir(b_dir), .o_cmd_valid(b_valid), .o_fire(b_fire), .o_led(b_led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounced level flips at edge e when the raw samples taken at edges e-2 .. e-DB-1 all
  // disagree with it and all of them were taken after the previous flip (or reset).
  logic [NB-1:0]   hist [0:4095];
  int              e_cnt = 0;
  int              last_flip [NB];
  logic [NB-1:0]   m_held = '0;
  logic [3*NP-1:0] m_dir = 6'b100100;
  logic [NP-1:0]   m_valid = '0, m_fire = '0, m_pend = '0, m_fire_nr = '0, m_pend_nr = '0;
  int              run [NP];

  function automatic logic [2:0] dir_of(input logic [4:0] h);
    if (h[0]) return 3'd0;
    if (h[1]) return 3'd1;
    if (h[2]) return 3'd2;
    if (h[3]) return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_step();
    logic [NB-1:0] nh;
    bit            all_diff, evt, evt_nr;
    int            cur;
    e_cnt++;
    if (!rst_n) begin
      hist[e_cnt % 4096] = '0;
      m_held = '0; m_dir = 6'b100100; m_valid = '0; m_fire = '0; m_pend = '0;
      m_fire_nr = '0; m_pend_nr = '0;
      for (int b = 0; b < NB; b++) last_flip[b] = e_cnt;
      for (int p = 0; p < NP; p++) run[p] = 0;
    end else begin
      hist[e_cnt % 4096] = i_btn;
      for (int p = 0; p < NP; p++) begin
        cur    = m_held[5*p+4] ? run[p] + 1 : 0;
        run[p] = cur;
        evt_nr = (cur == 1);
        evt    = evt_nr || (cur > 1 && (cur - 1) % RP == 0);
        if (i_frame_tick) begin
          m_dir[3*p +: 3] = dir_of(m_held[5*p +: 5]);
          m_fire[p] = m_pend[p];       m_pend[p] = evt;
          m_fire_nr[p] = m_pend_nr[p]; m_pend_nr[p] = evt_nr;
        end else begin
          m_fire[p] = 1'b0;    m_pend[p] = m_pend[p] | evt;
          m_fire_nr[p] = 1'b0; m_pend_nr[p] = m_pend_nr[p] | evt_nr;
        end
      end
      m_valid = i_frame_tick ? 2'b11 : 2'b00;
      nh = m_held;
      for (int b = 0; b < NB; b++) begin
        if (e_cnt >= last_flip[b] + DB) begin
          all_diff = 1'b1;
          for (int i = 0; i < DB; i++) begin
            if (hist[(e_cnt - 2 - i) % 4096][b] == m_held[b]) all_diff = 1'b0;
          end
          if (all_diff) begin
            nh[b] = ~m_held[b];
            last_flip[b] = e_cnt;
          end
        end
      end
      m_held = nh;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("held",     32'(a_held),  32'(m_held));
      check("led",      32'(a_led),   32'(m_held));
      check("dir",      32'(a_dir),   32'(m_dir));
      check("valid",    32'(a_valid), 32'(m_valid));
      check("fire",     32'(a_fire),  32'(m_fire));
      check("nr_held",  32'(b_held),  32'(m_held));
      check("nr_valid", 32'(b_valid), 32'(m_valid));
      check("nr_fire",  32'(b_fire),  32'(m_fire_nr));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    i_frame_tick = 1'b1;
    step(1);
    i_frame_tick = 1'b0;
  endtask

  task automatic wait_held(input int b, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (a_held[b]) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    step(3);
    check("rst_held",  32'(a_held),  32'd0);
    check("rst_dir",   32'(a_dir),   32'h24);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_fire",  32'(a_fire),  32'd0);
    rst_n = 1'b1;
    step(2);

    // Debounce latency on p0 up; 3-cycle glitch on p1 left must be filtered.
    i_btn[0] = 1'b1;
    i_btn[7] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 3) i_btn[7] = 1'b0;
      check($sformatf("db_lat_e%0d", k), 32'(a_held[0]), 32'(k == 6));
    end
    step(6);
    check("glitch_p1_left", 32'(a_held[7]), 32'd0);

    // Direction priority: up beats right.
    i_btn[3] = 1'b1;
    step(7);
    pulse_tick();
    check("prio_dir0", 32'(a_dir[2:0]), 32'd0);
    check("prio_dir1", 32'(a_dir[5:3]), 32'd4);
    check("prio_valid", 32'(a_valid), 32'd3);
    step(1);
    check("valid_drop", 32'(a_valid), 32'd0);
    i_btn = '0;
    step(8);
    pulse_tick();
    check("idle_dir0", 32'(a_dir[2:0]), 32'd4);

    // Auto-repeat on p1 fire, ticks every 10 cycles.
    i_btn[9] = 1'b1;
    wait_held(9, "wait_p1_fire");
    step(4);
    for (int s = 0; s < 4; s++) begin
      pulse_tick();
      check($sformatf("rpt_fire_s%0d", s), 32'(a_fire), 32'b10);
      check($sformatf("nr_fire_s%0d", s), 32'(b_fire[1]), 32'(s == 0));
      step(8);
    end
    i_btn[9] = 1'b0;
    step(8);
    pulse_tick();
    step(1);

    // Fire edge coincident with a tick is deferred to the next snapshot.
    i_btn[4] = 1'b1;
    wait_held(4, "wait_p0_fire");
    pulse_tick();
    check("same_cycle_fire", 32'(a_fire[0]), 32'd0);
    check("same_cycle_valid", 32'(a_valid), 32'd3);
    step(2);
    pulse_tick();
    check("deferred_fire", 32'(a_fire[0]), 32'd1);
    i_btn = '0;
    step(16);
    pulse_tick();
    step(2);

    // Reset mid-debounce: outputs clear asynchronously, full latency afterwards.
    i_btn[4] = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    check("arst_held",  32'(a_held),  32'd0);
    check("arst_dir",   32'(a_dir),   32'h24);
    check("arst_valid", 32'(a_valid), 32'd0);
    check("arst_fire",  32'(a_fire),  32'd0);
    step(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check($sformatf("post_rst_e%0d", k), 32'(a_held[4]), 32'(k == 6));
    end
    step(2);
    pulse_tick();
    check("post_rst_fire", 32'(a_fire[0]), 32'd1);
    i_btn = '0;
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
